// File: rtl/alu_exec_unit_pkg.sv
// Shared op codes, widths and FSM state type for the ALU execution unit.
package alu_exec_unit_pkg;

  localparam int unsigned ALU_XLEN = 32;
  localparam int unsigned ALU_SHW  = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_PASS = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b1101;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SRL) || (op == ALU_SLL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_unit_shift_iter.sv
// Iterative 1-bit-per-cycle shifter: shift register, latched fill bit
// and shift-amount down-counter.
module alu_shift_iter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] data,
  input  logic [SHW-1:0]  amount,
  input  logic            left,
  input  logic            arith,
  output logic [XLEN-1:0] shifted,
  output logic            last
);

  logic [XLEN-1:0] sreg;
  logic [SHW-1:0]  cnt;
  logic            dir_left;
  logic            fill;

  // Load operand/direction/fill on acceptance, then shift and count down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg     <= '0;
      cnt      <= '0;
      dir_left <= 1'b0;
      fill     <= 1'b0;
    end else if (load) begin
      sreg     <= data;
      cnt      <= amount;
      dir_left <= left;
      fill     <= arith & data[XLEN-1];
    end else if (step) begin
      sreg <= shifted;
      cnt  <= cnt - SHW'(1);
    end
  end

  // One-step shifted value; the top registers it as the result on the last step.
  always_comb begin
    shifted = dir_left ? {sreg[XLEN-2:0], 1'b0} : {fill, sreg[XLEN-1:1]};
    last    = (cnt == SHW'(1));
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execution unit: single-cycle arithmetic/logic/compare,
// iterative shifts, registered result and flags with a done pulse.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int unsigned XLEN = ALU_XLEN,
  parameter int unsigned SHW  = ALU_SHW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      sel,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            zf,
  output logic            cf,
  output logic            vf,
  output logic            sf
);

  state_t          state;
  logic            accept;
  logic            shift_op;
  logic [SHW-1:0]  shamt;
  logic [XLEN:0]   sum;
  logic [XLEN-1:0] bx;
  logic [XLEN-1:0] alu_res;
  logic            alu_cf;
  logic            alu_vf;
  logic [XLEN-1:0] shifted;
  logic            last;

  assign accept   = start && (state != S_SHIFT);
  assign shift_op = is_shift(sel);
  assign shamt    = b[SHW-1:0];

  alu_shift_iter #(
    .XLEN(XLEN),
    .SHW (SHW)
  ) u_shift (
    .clk    (clk),
    .rst    (rst),
    .load   (accept && shift_op),
    .step   (state == S_SHIFT),
    .data   (a),
    .amount (shamt),
    .left   (sel == ALU_SLL),
    .arith  (sel == ALU_SRA),
    .shifted(shifted),
    .last   (last)
  );

  // Single-cycle datapath and arithmetic flags; unknown codes act as PASS.
  always_comb begin
    bx      = b;
    sum     = '0;
    alu_res = b;
    alu_cf  = 1'b0;
    alu_vf  = 1'b0;
    case (sel)
      ALU_ADD, ALU_SUB: begin
        bx      = (sel == ALU_SUB) ? ~b : b;
        sum     = {1'b0, a} + {1'b0, bx} + {{XLEN{1'b0}}, (sel == ALU_SUB)};
        alu_res = sum[XLEN-1:0];
        alu_cf  = sum[XLEN];
        alu_vf  = (a[XLEN-1] == bx[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
      end
      ALU_OR:   alu_res = a | b;
      ALU_AND:  alu_res = a & b;
      ALU_XOR:  alu_res = a ^ b;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (a < b)};
      default:  alu_res = b;
    endcase
  end

  // Control FSM with registered busy/done/result/flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      zf     <= 1'b0;
      cf     <= 1'b0;
      vf     <= 1'b0;
      sf     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
          if (start) begin
            if (!shift_op) begin
              result <= alu_res;
              zf     <= (alu_res == '0);
              sf     <= alu_res[XLEN-1];
              cf     <= alu_cf;
              vf     <= alu_vf;
              done   <= 1'b1;
              state  <= S_DONE;
            end else if (shamt == '0) begin
              result <= a;
              zf     <= (a == '0);
              sf     <= a[XLEN-1];
              cf     <= 1'b0;
              vf     <= 1'b0;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              busy  <= 1'b1;
              state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          if (last) begin
            result <= shifted;
            zf     <= (shifted == '0);
            sf     <= shifted[XLEN-1];
            cf     <= 1'b0;
            vf     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus random ops
// compared against an arithmetic reference model.
module tb_alu_exec_unit;
  import alu_exec_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, zf, cf, vf, sf;
  logic [31:0] result;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  alu_exec_unit #(
    .XLEN(32),
    .SHW (5)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sel   (sel),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .result(result),
    .zf    (zf),
    .cf    (cf),
    .vf    (vf),
    .sf    (sf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] res;
    logic        cf;
    logic        vf;
    int          lat;
  } exp_t;

  // Reference: results from plain integer arithmetic on the op definitions.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    longint sx, sy, s;
    longint unsigned u;
    int sh;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = int'(y % 32);
    e.cf = 1'b0;
    e.vf = 1'b0;
    e.lat = 1;
    case (op)
      ALU_ADD: begin
        u = longint'(x) + longint'(y);
        e.res = u[31:0];
        e.cf = u[32];
        s = sx + sy;
        e.vf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      ALU_SUB: begin
        e.res = x - y;
        e.cf = (x >= y);
        s = sx - sy;
        e.vf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      ALU_OR:   e.res = x | y;
      ALU_AND:  e.res = x & y;
      ALU_XOR:  e.res = x ^ y;
      ALU_SRL:  e.res = x >> sh;
      ALU_SLL:  e.res = x << sh;
      ALU_SRA:  e.res = 32'($signed(x) >>> sh);
      ALU_SLT:  e.res = (sx < sy) ? 32'd1 : 32'd0;
      ALU_SLTU: e.res = (x < y) ? 32'd1 : 32'd0;
      default:  e.res = y;
    endcase
    if ((op == ALU_SRL || op == ALU_SLL || op == ALU_SRA) && sh != 0) e.lat = sh + 1;
    return e;
  endfunction

  // Issue one op at the current negedge; return at the negedge of its done cycle.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] x,
                       input logic [31:0] y, input bit glitch);
    exp_t e;
    int cyc;
    e = model(op, x, y);
    sel = op; a = x; b = y; start = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      check({tag, ".busy"}, {31'd0, busy}, {31'd0, (cyc < e.lat)});
      start = glitch ? 1'($urandom_range(0, 1)) : 1'b0;
      sel = 4'($urandom); a = $urandom; b = $urandom;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, ".lat"}, cyc, e.lat);
    check({tag, ".done"}, {31'd0, done}, 32'd1);
    check({tag, ".busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, ".result"}, result, e.res);
    check({tag, ".flags"}, {28'd0, zf, cf, vf, sf},
          {28'd0, (e.res == 32'd0), e.cf, e.vf, e.res[31]});
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset.outs", {result[31:0]}, 32'd0);
    check("reset.ctl", {26'd0, busy, done, zf, cf, vf, sf}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op("add_ovf", ALU_ADD, 32'h7FFFFFFF, 32'd1, 1'b0);
    idle_check("add_ovf");
    do_op("sub_eq", ALU_SUB, 32'd5, 32'd5, 1'b0);
    idle_check("sub_eq");
    do_op("sub_borrow", ALU_SUB, 32'd3, 32'd5, 1'b0);
    idle_check("sub_borrow");
    do_op("sra4", ALU_SRA, 32'h80000010, 32'd4, 1'b0);
    check("sra4.value", result, 32'hF8000001);
    idle_check("sra4");
    do_op("srl4", ALU_SRL, 32'h80000010, 32'd4, 1'b0);
    check("srl4.value", result, 32'h08000001);
    idle_check("srl4");
    do_op("sll31", ALU_SLL, 32'd1, 32'h0000003F, 1'b1);
    check("sll31.value", result, 32'h80000000);
    idle_check("sll31");
    do_op("sll0", ALU_SLL, 32'h00001234, 32'hFFFFFFE0, 1'b0);
    idle_check("sll0");
    do_op("slt", ALU_SLT, 32'hFFFFFFFF, 32'd1, 1'b0);
    do_op("sltu_b2b", ALU_SLTU, 32'hFFFFFFFF, 32'd1, 1'b0);
    idle_check("sltu_b2b");

    for (int i = 0; i < 40; i++) begin
      do_op("rand", 4'($urandom_range(0, 15)), $urandom, $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 0) idle_check("rand");
    end

    do_op("or_pre", ALU_OR, 32'h000000F0, 32'h0000000F, 1'b0);
    idle_check("or_pre");
    sel = ALU_SLL; a = 32'h0000_0003; b = 32'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid.busy_before", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid.result", result, 32'd0);
    check("rst_mid.ctl", {26'd0, busy, done, zf, cf, vf, sf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op("add_after_rst", ALU_ADD, 32'd2, 32'd3, 1'b0);
    idle_check("add_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
